// File: rtl/div4b_seq_if.sv
// Operand/result bundle for the 4-bit sequential divider.
// The master side drives the request; the slave side is the divider itself.
interface div4b_seq_if;
  logic       init;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       div_zero;

  modport master (output init, A, B, input Q, R, busy, done, div_zero);
  modport slave  (input init, A, B, output Q, R, busy, done, div_zero);
endinterface

// File: rtl/div4b_seq.sv
// 4-bit unsigned restoring divider, one quotient bit per clock, MSB first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for init; operands captured on accept
// S_CHECK | divisor test; zero divisor short-circuits to S_DONE
// S_ITER  | one trial subtraction per cycle, i counts 3 down to 0
// S_DONE  | done strobe for one cycle; Q/R/div_zero already loaded
module div4b_seq (
  input  logic        clk,
  input  logic        rst,
  div4b_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ITER, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] qw_q, qw_d;
  logic [3:0] q_q, q_d;
  logic [3:0] r_q, r_d;
  logic [1:0] i_q, i_d;
  logic       dz_q, dz_d;

  // Trial value: working remainder with the next dividend bit shifted in.
  // Kept 5 bits wide so a remainder near 15 does not wrap before the compare.
  logic [4:0] t;
  logic       ge;

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      qw_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      i_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      qw_q    <= qw_d;
      q_q     <= q_d;
      r_q     <= r_d;
      i_q     <= i_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state and datapath update; Q/R only change on the edge into S_DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    qw_d    = qw_q;
    q_d     = q_q;
    r_d     = r_q;
    i_d     = i_q;
    dz_d    = dz_q;

    t  = {rem_q, a_q[3]};
    ge = (t >= {1'b0, b_q});

    case (state_q)
      S_IDLE: begin
        if (bus.init) begin
          a_d     = bus.A;
          b_d     = bus.B;
          rem_d   = '0;
          qw_d    = '0;
          dz_d    = 1'b0;
          i_d     = 2'd3;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (b_q == 4'd0) begin
          q_d     = 4'hF;
          r_d     = a_q;
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        a_d       = {a_q[2:0], 1'b0};
        // When ge holds the true difference is below b_q, so 4 bits suffice.
        rem_d     = ge ? (t[3:0] - b_q) : t[3:0];
        qw_d[i_q] = ge;
        if (i_q == 2'd0) begin
          q_d     = qw_d;
          r_d     = rem_d;
          state_d = S_DONE;
        end else begin
          i_d = i_q - 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.Q        = q_q;
  assign bus.R        = r_q;
  assign bus.div_zero = dz_q;
  assign bus.busy     = (state_q == S_CHECK) || (state_q == S_ITER);
  assign bus.done     = (state_q == S_DONE);

endmodule

// File: tb/tb_div4b_seq.sv
// Directed-vector bench for div4b_seq: table of operand pairs with
// hand-computed results, plus busy-time, reset and back-to-back sequences.
module tb_div4b_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  div4b_seq_if bus ();

  div4b_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Accept (a, b) at cycle 0 and record busy/done for cycles 1..12.
  task automatic run_vec(input logic [3:0] a, input logic [3:0] b,
                         output logic [15:0] busy_m, output logic [15:0] done_m);
    busy_m   = '0;
    done_m   = '0;
    bus.A    = a;
    bus.B    = b;
    bus.init = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) bus.init = 1'b0;
      busy_m[k] = bus.busy;
      done_m[k] = bus.done;
    end
  endtask

  initial begin
    logic [15:0] bm, dm;
    logic [7:0]  idx;
    int          prev_done, waited, exp_gap;
    logic [3:0]  sa, sb, eq, er;

    vecs[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1, dz: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0};
    vecs[2] = '{a: 4'd3,  b: 4'd7,  q: 4'd0,  r: 4'd3, dz: 1'b0};
    vecs[3] = '{a: 4'd0,  b: 4'd9,  q: 4'd0,  r: 4'd0, dz: 1'b0};
    vecs[4] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0};
    vecs[5] = '{a: 4'd5,  b: 4'd0,  q: 4'hF,  r: 4'd5, dz: 1'b1};
    vecs[6] = '{a: 4'd6,  b: 4'd3,  q: 4'd2,  r: 4'd0, dz: 1'b0};
    vecs[7] = '{a: 4'd14, b: 4'd3,  q: 4'd4,  r: 4'd2, dz: 1'b0};
    vecs[8] = '{a: 4'd15, b: 4'd14, q: 4'd1,  r: 4'd1, dz: 1'b0};
    vecs[9] = '{a: 4'd12, b: 4'd5,  q: 4'd2,  r: 4'd2, dz: 1'b0};

    bus.init = 1'b0;
    bus.A    = '0;
    bus.B    = '0;
    rst      = 1'b1;
    tick();
    tick();
    chk("reset_Q",    bus.Q,        0);
    chk("reset_R",    bus.R,        0);
    chk("reset_busy", bus.busy,     0);
    chk("reset_done", bus.done,     0);
    chk("reset_dz",   bus.div_zero, 0);
    rst = 1'b0;
    tick();

    // Directed table; 5/0 followed by 6/3 checks div_zero clears again.
    for (int v = 0; v < 10; v++) begin
      run_vec(vecs[v].a, vecs[v].b, bm, dm);
      chk($sformatf("v%0d_busy_mask", v), bm, vecs[v].dz ? 16'h0002 : 16'h003E);
      chk($sformatf("v%0d_done_mask", v), dm, vecs[v].dz ? 16'h0004 : 16'h0040);
      chk($sformatf("v%0d_Q", v),  bus.Q,        vecs[v].q);
      chk($sformatf("v%0d_R", v),  bus.R,        vecs[v].r);
      chk($sformatf("v%0d_dz", v), bus.div_zero, vecs[v].dz);
    end

    // Busy-time: operands wiggle and a second init arrives at cycle 3.
    bm = '0;
    dm = '0;
    bus.A    = 4'd9;
    bus.B    = 4'd2;
    bus.init = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      case (k)
        1: begin bus.init = 1'b0; bus.A = 4'd14; bus.B = 4'd3; end
        2: begin bus.A = 4'd1; bus.B = 4'd0; end
        3: begin bus.init = 1'b1; bus.A = 4'd14; bus.B = 4'd3; end
        4: begin bus.init = 1'b0; bus.A = 4'd7; bus.B = 4'd5; end
        5: begin bus.A = 4'd0; bus.B = 4'd15; end
        default: ;
      endcase
      bm[k] = bus.busy;
      dm[k] = bus.done;
    end
    chk("busy_ign_busy_mask", bm, 16'h003E);
    chk("busy_ign_done_mask", dm, 16'h0040);
    chk("busy_ign_Q", bus.Q, 4);
    chk("busy_ign_R", bus.R, 1);

    // Reset mid-operation at cycle 4 of 11/3.
    dm = '0;
    bus.A    = 4'd11;
    bus.B    = 4'd3;
    bus.init = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) bus.init = 1'b0;
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        chk("midrst_Q",    bus.Q,        0);
        chk("midrst_R",    bus.R,        0);
        chk("midrst_busy", bus.busy,     0);
        chk("midrst_done", bus.done,     0);
        chk("midrst_dz",   bus.div_zero, 0);
        rst = 1'b0;
      end
      dm[k] = bus.done;
    end
    chk("midrst_no_done", dm, 16'h0000);
    run_vec(4'd11, 4'd3, bm, dm);
    chk("after_rst_done_mask", dm, 16'h0040);
    chk("after_rst_Q", bus.Q, 3);
    chk("after_rst_R", bus.R, 2);

    // Sweep with init held high. A normal op ends 7 cycles after the previous
    // done; a zero divisor skips the iterations, so its gap is only 3.
    idx       = 8'd0;
    bus.A     = idx[7:4];
    bus.B     = idx[3:0];
    bus.init  = 1'b1;
    prev_done = cyc - 1;
    waited    = 0;
    for (int n = 0; n < 256; ) begin
      tick();
      waited++;
      if (bus.done) begin
        sa = idx[7:4];
        sb = idx[3:0];
        if (sb == 4'd0) begin
          eq      = 4'hF;
          er      = sa;
          exp_gap = 3;
        end else begin
          eq      = sa / sb;
          er      = sa % sb;
          exp_gap = 7;
        end
        chk($sformatf("sweep_%0d_%0d_gap", sa, sb), cyc - prev_done, exp_gap);
        chk($sformatf("sweep_%0d_%0d_Q", sa, sb),  bus.Q, eq);
        chk($sformatf("sweep_%0d_%0d_R", sa, sb),  bus.R, er);
        chk($sformatf("sweep_%0d_%0d_dz", sa, sb), bus.div_zero, (sb == 4'd0) ? 1 : 0);
        prev_done = cyc;
        waited    = 0;
        n++;
        idx   = idx + 8'd1;
        bus.A = idx[7:4];
        bus.B = idx[3:0];
      end else if (waited > 20) begin
        chk("sweep_timeout", waited, 7);
        break;
      end
    end
    bus.init = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
